// File: rtl/cby_param_ccff_shadow.sv
// Parametrised Y-direction connection block. A serial config chain loads a shadow
// image that is copied atomically to the active select register on a commit strobe.
module cby_param_ccff_shadow #(
  parameter int CHAN_WIDTH = 9,
  parameter int NUM_IPIN   = 10,
  parameter int MUX_SIZE   = 6,
  parameter int SEL_BITS   = 3,
  parameter int TRACK_STEP = 4,
  parameter int TOTAL_BITS = NUM_IPIN * SEL_BITS
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  output logic [CHAN_WIDTH-1:0] chany_bottom_out,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  output logic [NUM_IPIN-1:0]   ipin_out,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  ccff_commit,
  input  logic                  ccff_clear,
  output logic                  ccff_tail,
  output logic                  cfg_armed,
  output logic                  cfg_err
);

  localparam int CNT_W = $clog2(TOTAL_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(TOTAL_BITS + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  if ((MUX_SIZE % 2) != 0 || MUX_SIZE > 2 * CHAN_WIDTH || (1 << SEL_BITS) < MUX_SIZE)
  begin : g_bad_params
    $error("cby_param_ccff_shadow: inconsistent MUX_SIZE / SEL_BITS / CHAN_WIDTH");
  end

  logic [TOTAL_BITS-1:0] chain_q, chain_d;
  logic [TOTAL_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            state_q, state_d;
  logic                  err_q, err_d;
  logic                  commit_ok;

  function automatic logic [1:0] state_of(input logic [CNT_W-1:0] c);
    if (c == '0)
      return ST_IDLE;
    else if (c < CNT_FULL)
      return ST_SHIFT;
    else if (c == CNT_FULL)
      return ST_ARMED;
    else
      return ST_OVER;
  endfunction

  // Commit is judged on the pre-edge state, so a shift in the same cycle never
  // leaks into the active image.
  always_comb begin
    chain_d   = chain_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    err_d     = err_q;
    commit_ok = ccff_commit && (state_q == ST_ARMED);

    if (ccff_en)
      chain_d = {chain_q[TOTAL_BITS-2:0], ccff_head};

    if (ccff_clear) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
      err_d   = 1'b0;
    end else begin
      if (ccff_en && cnt_q != CNT_OVER)
        cnt_d = cnt_q + CNT_W'(1);
      if (ccff_commit) begin
        if (commit_ok) begin
          active_d = chain_q;
          cnt_d    = '0;
          if (ccff_en)
            err_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      state_d = state_of(cnt_d);
      if (state_d == ST_OVER)
        err_d = 1'b1;
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      chain_q  <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail        = chain_q[TOTAL_BITS-1];
  assign cfg_armed        = (state_q == ST_ARMED);
  assign cfg_err          = err_q;
  assign chany_bottom_out = chany_top_in;
  assign chany_top_out    = chany_bottom_in;

  // Input k of pin i taps track (i + (k>>1)*TRACK_STEP) mod CHAN_WIDTH; even k from
  // below, odd k from above. Selects past MUX_SIZE match no input and drive 0.
  always_comb begin
    logic [SEL_BITS-1:0] sel;
    int                  t;
    ipin_out = '0;
    sel      = '0;
    t        = 0;
    for (int i = 0; i < NUM_IPIN; i++) begin
      sel = active_q[i*SEL_BITS +: SEL_BITS];
      for (int k = 0; k < MUX_SIZE; k++) begin
        t = (i + (k / 2) * TRACK_STEP) % CHAN_WIDTH;
        if (int'(sel) == k)
          ipin_out[i] = ((k % 2) != 0) ? chany_top_in[t] : chany_bottom_in[t];
      end
    end
  end

endmodule

// File: tb/tb_cby_param_ccff_shadow.sv
// Randomised bench for cby_param_ccff_shadow with a queue-based behavioural model.
module tb_cby_param_ccff_shadow;
  localparam int CW = 9;
  localparam int NI = 10;
  localparam int MS = 6;
  localparam int SB = 3;
  localparam int TS = 4;
  localparam int TB = NI * SB;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] bot_in, top_in, bot_out, top_out;
  logic [NI-1:0] ipin;
  logic          head, en, commit, clear;
  logic          tail, armed, err;

  int checks = 0;
  int failures = 0;

  cby_param_ccff_shadow dut (
    .prog_clk(clk), .pReset(rst),
    .chany_bottom_in(bot_in), .chany_top_in(top_in),
    .chany_bottom_out(bot_out), .chany_top_out(top_out),
    .ipin_out(ipin),
    .ccff_head(head), .ccff_en(en), .ccff_commit(commit), .ccff_clear(clear),
    .ccff_tail(tail), .cfg_armed(armed), .cfg_err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: chain as a queue (index 0 = first chain bit), count, error
  // flag and the active select value of each pin as plain integers.
  bit m_chain[$];
  int m_cnt;
  bit m_err;
  int m_act[NI];

  task automatic m_reset();
    m_chain = {};
    for (int k = 0; k < TB; k++) m_chain.push_back(1'b0);
    m_cnt = 0;
    m_err = 1'b0;
    for (int i = 0; i < NI; i++) m_act[i] = 0;
  endtask

  function automatic int m_sel(int i);
    int s = 0;
    for (int b = 0; b < SB; b++) s += int'(m_chain[i*SB + b]) << b;
    return s;
  endfunction

  function automatic logic [NI-1:0] m_ipin(logic [CW-1:0] b, logic [CW-1:0] t);
    logic [NI-1:0] r = '0;
    for (int i = 0; i < NI; i++) begin
      int s = m_act[i];
      if (s < MS) begin
        int tr = (i + (s / 2) * TS) % CW;
        r[i] = (s % 2 == 1) ? t[tr] : b[tr];
      end
    end
    return r;
  endfunction

  task automatic m_clock(bit h, bit e, bit c, bit cl);
    bit was_armed = (m_cnt == TB);
    bit took = 1'b0;
    if (cl) begin
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      if (c) begin
        if (was_armed) begin
          for (int i = 0; i < NI; i++) m_act[i] = m_sel(i);
          m_cnt = 0;
          took = 1'b1;
          if (e) m_err = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (e && !took) m_cnt = (m_cnt + 1 > TB + 1) ? TB + 1 : m_cnt + 1;
      if (m_cnt > TB) m_err = 1'b1;
    end
    if (e) begin
      m_chain.push_front(h);
      void'(m_chain.pop_back());
    end
  endtask

  task automatic check_outputs();
    chk("tail", tail, m_chain[TB-1]);
    chk("armed", armed, m_cnt == TB);
    chk("err", err, m_err);
    chk("ipin", ipin, m_ipin(bot_in, top_in));
    chk("top_out", top_out, bot_in);
    chk("bot_out", bot_out, top_in);
  endtask

  task automatic step(input bit h, input bit e, input bit c, input bit cl);
    bot_in = CW'($urandom);
    top_in = CW'($urandom);
    head = h; en = e; commit = c; clear = cl;
    @(posedge clk);
    m_clock(h, e, c, cl);
    #1;
    check_outputs();
    head = 1'b0; en = 1'b0; commit = 1'b0; clear = 1'b0;
  endtask

  int want[NI];
  bit stream[TB];

  // Shift n bits so that, after TB of them, pin i holds want[i]; extra bits are random.
  task automatic shift_want(input int n);
    for (int j = 0; j < n; j++) begin
      int p = TB - 1 - j;
      bit b;
      if (p >= 0) b = bit'((want[p / SB] >> (p % SB)) & 1);
      else b = bit'($urandom_range(0, 1));
      if (j < TB) stream[j] = b;
      step(b, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic clear_want();
    for (int i = 0; i < NI; i++) want[i] = 0;
  endtask

  initial begin
    rst = 1'b1;
    bot_in = '0; top_in = '0;
    head = 1'b0; en = 1'b0; commit = 1'b0; clear = 1'b0;
    m_reset();
    #11;
    chk("rst_tail", tail, 1'b0);
    chk("rst_armed", armed, 1'b0);
    chk("rst_err", err, 1'b0);
    #1;
    rst = 1'b0;

    // Idle after reset: every pin on input 0
    bot_in = 9'h001; top_in = 9'h000;
    #1;
    chk("t1_ipin0", ipin[0], 1'b1);
    chk("t1_ipin1", ipin[1], 1'b0);
    chk("t1_top_out", top_out, 9'h001);
    chk("t1_err", err, 1'b0);

    // Full load, ipin0 sel=3 -> chany_top_in[4]
    clear_want();
    want[0] = 3;
    shift_want(TB);
    chk("t2_armed", armed, 1'b1);
    chk("t2_pre_commit_ipin0", ipin[0], bot_in[0]);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_armed_after", armed, 1'b0);
    top_in = 9'h010; bot_in = 9'h1ef;
    #1;
    chk("t2_ipin0_hi", ipin[0], 1'b1);
    top_in = 9'h1ef; bot_in = 9'h010;
    #1;
    chk("t2_ipin0_lo", ipin[0], 1'b0);

    // Short load then commit: rejected, error sticky until clear
    want[0] = 5;
    shift_want(TB - 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_err", err, 1'b1);
    top_in = 9'h010; bot_in = 9'h000;
    #1;
    chk("t3_active_kept", ipin[0], 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_err_cleared", err, 1'b0);
    shift_want(TB);
    chk("t3_armed_from_zero", armed, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    top_in = 9'h100; bot_in = 9'h000;
    #1;
    chk("t3_ipin0_top8", ipin[0], 1'b1);

    // Overlong load
    want[0] = 1;
    shift_want(TB + 1);
    chk("t4_err", err, 1'b1);
    chk("t4_not_armed", armed, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    top_in = 9'h100; bot_in = 9'h000;
    #1;
    chk("t4_active_kept", ipin[0], 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Out-of-range select on ipin2
    clear_want();
    want[2] = 6;
    shift_want(TB);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    bot_in = '1; top_in = '1;
    #1;
    chk("t5_ipin2_ones", ipin[2], 1'b0);
    for (int r = 0; r < 6; r++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_ipin2", ipin[2], 1'b0);
    end

    // Readback of a random load through ccff_tail
    for (int i = 0; i < NI; i++) want[i] = int'($urandom_range(0, 7));
    shift_want(TB);
    for (int j = 0; j < TB; j++) begin
      chk("t6_readback", tail, stream[j]);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Reset in the middle of a load
    shift_want(20);
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    chk("t6_rst_tail", tail, 1'b0);
    chk("t6_rst_armed", armed, 1'b0);
    chk("t6_rst_err", err, 1'b0);
    for (int i = 0; i < NI; i++) chk("t6_rst_ipin", ipin[i], bot_in[i % CW]);
    #3;
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int r = int'($urandom_range(0, 99));
      bit c = (r < 6);
      bit cl = (r >= 97);
      bit e = ($urandom_range(0, 99) < 75);
      step(bit'($urandom_range(0, 1)), e, c, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
